record_serializer: RTL

Downstream stage of the sequence parser: accepts each 296-bit parsed record over a valid/ready handshake and re-emits it as a stream of 32-bit words with a last flag toward the 32-bit egress path. Holds up to DEPTH records so the parser can run ahead while egress is back-pressured. Also counts the parser's packet-loss pulses for status readout.

---
 rtl/record_serializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/record_serializer.sv
// record_serializer: buffers whole parsed records in a small circular FIFO
// and replays the head record as a stream of WORD_W-bit words with a last
// flag. Also keeps a saturating count of parser packet-loss pulses.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | buffer empty, no word presented
// SEND  | head record is being presented, word r_idx on word_out
module record_serializer #(
    parameter int REC_W  = 296,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [0:REC_W-1]  rec_in,
    input  logic              rec_in_val,
    output logic              rec_in_ready,
    input  logic              packet_lost,
    input  logic              lost_clr,
    output logic [WORD_W-1:0] word_out,
    output logic              word_out_val,
    input  logic              word_out_ready,
    output logic              word_out_last,
    output logic [15:0]       lost_count
);

    localparam int NWORDS = (REC_W + WORD_W - 1) / WORD_W;
    localparam int PAD_W  = NWORDS * WORD_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [0:REC_W-1]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_lost;
    state_t            r_state;
    state_t            w_state_next;

    logic              w_push;
    logic              w_xfer;
    logic              w_pop;
    logic [PAD_W-1:0]  w_padded;
    logic [WORD_W-1:0] w_word;

    // Record bit 0 lands in the MSB of the padded vector, so word k is a
    // simple descending slice and the tail word is zero-filled.
    assign w_padded = PAD_W'(r_mem[r_rd]) << (PAD_W - REC_W);
    assign w_word   = w_padded[PAD_W - 1 - int'(r_idx) * WORD_W -: WORD_W];

    // Ready looks only at the registered occupancy: no pass-through when full.
    assign rec_in_ready = (r_count < CNT_W'(DEPTH));
    assign w_push       = rec_in_val && rec_in_ready;
    assign w_xfer       = word_out_val && word_out_ready;
    assign w_pop        = w_xfer && (r_idx == IDX_W'(NWORDS - 1));
    assign lost_count   = r_lost;

    // Record storage, written whole on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= rec_in;
        end
    end

    // FIFO pointers, occupancy and word index.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_xfer) begin
                if (w_pop) begin
                    r_idx <= '0;
                    r_rd  <= r_rd + 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and word outputs; word_out is zero whenever nothing is valid.
    always_comb begin
        w_state_next  = r_state;
        word_out_val  = 1'b0;
        word_out_last = 1'b0;
        word_out      = '0;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                word_out_val  = 1'b1;
                word_out_last = (r_idx == IDX_W'(NWORDS - 1));
                word_out      = w_word;
                if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Saturating loss counter; clear wins over a simultaneous pulse.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_lost <= '0;
        end else if (lost_clr) begin
            r_lost <= '0;
        end else if (packet_lost && (r_lost != 16'hFFFF)) begin
            r_lost <= r_lost + 16'd1;
        end
    end

endmodule
